// File: rtl/dac_arb.sv
// dac_arb: round-robin arbiter and sequencer for the shared AD5331 DAC
// control register port. Each granted requester gets one register write,
// the controller busy flag is tracked through the conversion, then the
// requester is acknowledged (with err on abort/timeout). Power-down changes
// on pd_en are pushed to the DAC as internal writes that take priority.
//
// Optional build macro: DAC_ARB_FIXED_PRIO_EN
//   defined   -> requester 0 wins over the round-robin choice when set;
//                requesters 1..N-1 stay round-robin among themselves.
//   undefined -> pure round-robin across all N requesters.
module dac_arb #(
   parameter int unsigned N       = 4,
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned HI_WIN  = 3
) (
   input  logic            clk,
   input  logic            rst_,
   input  logic [N-1:0]    req,
   input  logic [N*10-1:0] req_code,
   input  logic [N-1:0]    req_clr,
   output logic [N-1:0]    ack,
   output logic            err,
   output logic [2:0]      grant_id,
   output logic            arb_busy,
   input  logic            pd_en,
   output logic            dac_valid,
   output logic            dac_sel,
   output logic            dac_rd_wr,
   output logic [31:0]     dac_wdata,
   input  logic            dac_busy
);

   // Register field positions, matching DAN_DAC_1 / CLR_DAC_1 / PD_DAC
   // of g_define.vh.
   localparam int unsigned CODE_LSB = 0;
   localparam int unsigned CLR_BIT  = 10;
   localparam int unsigned PD_BIT   = 11;

   // One counter serves both wait windows; size it for the larger one.
   localparam int unsigned CMAX = (TIMEOUT > HI_WIN) ? TIMEOUT : HI_WIN;
   localparam int unsigned CW   = $clog2(CMAX + 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_HI,
      WAIT_LO,
      DONE
   } state_t;

   state_t          state;
   state_t          next_state;

   logic [CW-1:0]   cnt;
   logic [2:0]      ptr;
   logic            pd_last;
   logic            internal_op;
   logic            err_flag;
   logic [9:0]      last_code;

   logic            found;
   int unsigned     pick_i;
   logic [2:0]      pick;
   logic [9:0]      pick_code;
   logic            pick_clr;

   logic            start_pd;
   logic            start_req;
   logic            fail;

   function automatic logic [31:0] pack_word(input logic [9:0] code,
                                             input logic       clr,
                                             input logic       pd);
      logic [31:0] w;
      w                   = '0;
      w[CODE_LSB +: 10]   = code;
      w[CLR_BIT]          = clr;
      w[PD_BIT]           = pd;
      return w;
   endfunction

   assign dac_rd_wr = 1'b1;

   // Pick the first pending requester searching upward from ptr+1 (mod N).
   always_comb begin
      int unsigned idx;
      found  = 1'b0;
      pick_i = 0;
      idx    = 0;
      for (int unsigned k = 1; k <= N; k++) begin
         idx = {29'd0, ptr} + k;
         if (idx >= N) idx = idx - N;
         if (!found && req[idx]) begin
            found  = 1'b1;
            pick_i = idx;
         end
      end
`ifdef DAC_ARB_FIXED_PRIO_EN
      if (req[0]) begin
         found  = 1'b1;
         pick_i = 0;
      end
`else
`endif
   end

   assign pick      = 3'(pick_i);
   assign pick_code = req_code[pick_i*10 +: 10];
   assign pick_clr  = req_clr[pick_i];

   // State register.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state decode and per-state outputs.
   always_comb begin
      next_state = state;
      ack        = '0;
      err        = 1'b0;
      dac_valid  = 1'b0;
      dac_sel    = 1'b0;
      arb_busy   = (state != IDLE);
      start_pd   = 1'b0;
      start_req  = 1'b0;
      fail       = 1'b0;
      case (state)
         IDLE: begin
            if (pd_en != pd_last) begin
               start_pd   = 1'b1;
               next_state = ISSUE;
            end else if (pd_en && found) begin
               start_req  = 1'b1;
               next_state = ISSUE;
            end
         end
         ISSUE: begin
            dac_valid  = 1'b1;
            dac_sel    = 1'b1;
            next_state = WAIT_HI;
         end
         WAIT_HI: begin
            if (dac_busy) begin
               next_state = WAIT_LO;
            end else if (cnt == CW'(HI_WIN - 1)) begin
               fail       = 1'b1;
               next_state = DONE;
            end
         end
         WAIT_LO: begin
            // Power loss aborts a requester op; an internal pd write is the
            // very thing changing power, so it is exempt.
            if (!pd_en && !internal_op) begin
               fail       = 1'b1;
               next_state = DONE;
            end else if (!dac_busy) begin
               next_state = DONE;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               fail       = 1'b1;
               next_state = DONE;
            end
         end
         DONE: begin
            if (!internal_op) begin
               ack = N'(1) << grant_id;
               err = err_flag;
            end
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Wait counter: cleared on every state change, counts while waiting.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         cnt <= '0;
      end else if (state != next_state) begin
         cnt <= '0;
      end else if (state == WAIT_HI || state == WAIT_LO) begin
         cnt <= cnt + CW'(1);
      end
   end

   // Operation launch: latch register word, owner and op kind.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         dac_wdata   <= '0;
         grant_id    <= '0;
         pd_last     <= 1'b0;
         internal_op <= 1'b0;
      end else if (start_pd) begin
         dac_wdata   <= pack_word(last_code, 1'b0, pd_en);
         pd_last     <= pd_en;
         internal_op <= 1'b1;
      end else if (start_req) begin
         dac_wdata   <= pack_word(pick_code, pick_clr, 1'b1);
         grant_id    <= pick;
         internal_op <= 1'b0;
      end
   end

   // Error flag for the operation in flight.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_)                       err_flag <= 1'b0;
      else if (start_pd || start_req)  err_flag <= 1'b0;
      else if (fail)                   err_flag <= 1'b1;
   end

   // Completion bookkeeping: rotate pointer, remember last good code.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         ptr       <= 3'(N - 1);
         last_code <= '0;
      end else if (state == DONE && !internal_op) begin
         ptr <= grant_id;
         if (!err_flag && !dac_wdata[CLR_BIT])
            last_code <= dac_wdata[CODE_LSB +: 10];
      end
   end

endmodule

// File: tb/tb_dac_arb.sv
// Self-checking bench for dac_arb: directed steps in one initial block,
// with a scoreboard of expected register writes and acknowledgements.
module tb_dac_arb;

   localparam int unsigned N = 4;

   logic            clk;
   logic            rst_;
   logic [N-1:0]    req;
   logic [N*10-1:0] req_code;
   logic [N-1:0]    req_clr;
   logic [N-1:0]    ack;
   logic            err;
   logic [2:0]      grant_id;
   logic            arb_busy;
   logic            pd_en;
   logic            dac_valid;
   logic            dac_sel;
   logic            dac_rd_wr;
   logic [31:0]     dac_wdata;
   logic            dac_busy;

   dac_arb #(.N(N), .TIMEOUT(255), .HI_WIN(3)) dut (
      .clk       (clk),
      .rst_      (rst_),
      .req       (req),
      .req_code  (req_code),
      .req_clr   (req_clr),
      .ack       (ack),
      .err       (err),
      .grant_id  (grant_id),
      .arb_busy  (arb_busy),
      .pd_en     (pd_en),
      .dac_valid (dac_valid),
      .dac_sel   (dac_sel),
      .dac_rd_wr (dac_rd_wr),
      .dac_wdata (dac_wdata),
      .dac_busy  (dac_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] id;
      logic       e;
   } ack_t;

   logic [31:0] wq[$];
   ack_t        aq[$];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   valid_cyc = 0;
   int   ack_cyc = 0;
   int   req_cyc = 0;
   int   nwrites = 0;
   int   nw0 = 0;
   int   bmode = 0;
   int   blen = 4;
   int   left = 0;
   logic pend = 1'b0;
   logic prev_valid = 1'b0;
   logic reassert0 = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: observe outputs on the falling edge, then act as the
   // requesters (drop on ack) and as the DAC controller busy flag.
   task automatic tick();
      ack_t a;
      @(negedge clk);
      cyc++;
      if (dac_valid) begin
         nwrites++;
         valid_cyc = cyc;
         chk("dac_sel", {31'd0, dac_sel}, 32'd1);
         chk("dac_rd_wr", {31'd0, dac_rd_wr}, 32'd1);
         if (prev_valid) chk("valid_width", {31'd0, dac_valid}, 32'd0);
         if (wq.size() == 0) chk("valid_unexp", {31'd0, dac_valid}, 32'd0);
         else chk("wdata", dac_wdata, wq.pop_front());
      end
      prev_valid = dac_valid;
      if (ack != '0) begin
         ack_cyc = cyc;
         if (aq.size() == 0) begin
            chk("ack_unexp", {28'd0, ack}, 32'd0);
         end else begin
            a = aq.pop_front();
            chk("ack_vec", {28'd0, ack}, 32'd1 << a.id);
            chk("ack_err", {31'd0, err}, {31'd0, a.e});
            chk("ack_gid", {29'd0, grant_id}, {29'd0, a.id});
         end
      end else if (err) begin
         chk("err_no_ack", {31'd0, err}, 32'd0);
      end
      if (ack[1] && reassert0) begin
         req[1]    = 1'b0;
         req[0]    = 1'b1;
         reassert0 = 1'b0;
         req       = req & ~(ack & 4'b1101);
      end else begin
         req = req & ~ack;
      end
      if (!rst_) begin
         dac_busy = 1'b0; pend = 1'b0; left = 0;
      end else if (dac_valid) begin
         pend = 1'b1;
      end else if (pend) begin
         pend = 1'b0;
         if (bmode == 1) dac_busy = 1'b0;
         else begin dac_busy = 1'b1; left = blen - 1; end
      end else if (bmode == 2) begin
         dac_busy = 1'b1;
      end else if (left > 0) begin
         left--;
      end else begin
         dac_busy = 1'b0;
      end
   endtask

   task automatic wait_done(input string tag, input int limit);
      int   n;
      logic ok;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < limit) begin
         tick();
         n++;
         ok = (wq.size() == 0) && (aq.size() == 0) && !arb_busy;
      end
      chk({"done_", tag}, {31'd0, ok}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int   ord[5];
      logic seen;
      rst_     = 1'b0;
      req      = '0;
      req_clr  = '0;
      req_code = '0;
      pd_en    = 1'b0;
      dac_busy = 1'b0;
      #1;
      chk("rst_ack", {28'd0, ack}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_valid", {31'd0, dac_valid}, 32'd0);
      chk("rst_sel", {31'd0, dac_sel}, 32'd0);
      chk("rst_wdata", dac_wdata, 32'd0);
      chk("rst_gid", {29'd0, grant_id}, 32'd0);
      chk("rst_busy", {31'd0, arb_busy}, 32'd0);
      chk("rst_rdwr", {31'd0, dac_rd_wr}, 32'd1);
      tick(); tick();
      rst_ = 1'b1;
      tick();
      chk("idle_no_write", nwrites, 0);

      // Power-up: internal write of code 0 with PD set, no ack.
      wq.push_back(32'h0000_0800);
      pd_en = 1'b1;
      wait_done("pd_up", 100);

      // Round-robin with all four requesting; req[0] comes back after grant 1.
`ifdef DAC_ARB_FIXED_PRIO_EN
      ord = '{0, 1, 0, 2, 3};
`else
      ord = '{0, 1, 2, 3, 0};
`endif
      for (int i = 0; i < 5; i++) begin
         wq.push_back(32'h800 | (32'h100 + 32'(ord[i])));
         aq.push_back(ack_t'{3'(ord[i]), 1'b0});
      end
      for (int i = 0; i < 4; i++) req_code[i*10 +: 10] = 10'(10'h100 + i);
      reassert0 = 1'b1;
      req = 4'b1111;
      wait_done("rr", 200);

      // Single load with latency checks.
      wq.push_back(32'h0000_0AA5);
      aq.push_back(ack_t'{3'd2, 1'b0});
      req_code[20 +: 10] = 10'h2A5;
      req[2]  = 1'b1;
      req_cyc = cyc;
      wait_done("load2", 60);
      chk("lat_issue", 32'(valid_cyc - req_cyc), 32'd1);
      chk("lat_ack", 32'(ack_cyc - valid_cyc), 32'd6);
      chk("gid_hold", {29'd0, grant_id}, 32'd2);

      // Clear request: CLR bit set, last code left alone.
      wq.push_back(32'h0000_0FC3);
      aq.push_back(ack_t'{3'd1, 1'b0});
      req_code[10 +: 10] = 10'h3C3;
      req_clr[1] = 1'b1;
      req[1]     = 1'b1;
      wait_done("clr1", 60);
      req_clr[1] = 1'b0;

      // Power-down with a pending request: pd write first, then no grant.
      wq.push_back(32'h0000_02A5);
      req_code[30 +: 10] = 10'h0F0;
      pd_en  = 1'b0;
      req[3] = 1'b1;
      wait_done("pd_down", 60);
      nw0 = nwrites;
      repeat (20) tick();
      chk("pd_block", nwrites, nw0);
      chk("pd_block_idle", {31'd0, arb_busy}, 32'd0);
      wq.push_back(32'h0000_0AA5);
      wq.push_back(32'h0000_08F0);
      aq.push_back(ack_t'{3'd3, 1'b0});
      pd_en = 1'b1;
      wait_done("pd_release", 100);

      // Busy never asserts: error after the HI window.
      bmode = 1;
      wq.push_back(32'h0000_0855);
      aq.push_back(ack_t'{3'd1, 1'b1});
      req_code[10 +: 10] = 10'h055;
      req[1] = 1'b1;
      wait_done("no_busy", 60);
      chk("lat_hi_err", 32'(ack_cyc - valid_cyc), 32'd4);

      // Busy stuck high: timeout in WAIT_LO.
      bmode = 2;
      wq.push_back(32'h0000_09AA);
      aq.push_back(ack_t'{3'd2, 1'b1});
      req_code[20 +: 10] = 10'h1AA;
      req[2] = 1'b1;
      wait_done("stuck", 400);
      chk("lat_lo_err", 32'(ack_cyc - valid_cyc), 32'd257);
      bmode = 0;
      left  = 0;
      tick();

      // Power drop in WAIT_LO aborts; the pd write reuses the last good code.
      blen = 30;
      wq.push_back(32'h0000_0B33);
      aq.push_back(ack_t'{3'd0, 1'b1});
      req_code[0 +: 10] = 10'h333;
      req[0] = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         seen = (wq.size() == 0);
      end
      chk("abort_issue", {31'd0, seen}, 32'd1);
      repeat (4) tick();
      wq.push_back(32'h0000_00F0);
      pd_en = 1'b0;
      wait_done("pd_abort", 100);
      blen = 4;
      wq.push_back(32'h0000_08F0);
      pd_en = 1'b1;
      wait_done("pd_up2", 60);

      // Reset in the middle of an operation: no ack, reset values at once.
      wq.push_back(32'h0000_0911);
      req_code[10 +: 10] = 10'h111;
      req[1] = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         seen = (wq.size() == 0);
      end
      chk("rst_mid_issue", {31'd0, seen}, 32'd1);
      tick(); tick();
      rst_ = 1'b0;
      req  = '0;
      #1;
      chk("rst_mid_busy", {31'd0, arb_busy}, 32'd0);
      chk("rst_mid_wdata", dac_wdata, 32'd0);
      chk("rst_mid_gid", {29'd0, grant_id}, 32'd0);
      chk("rst_mid_ack", {28'd0, ack}, 32'd0);
      tick(); tick();
      wq.push_back(32'h0000_0800);
      rst_ = 1'b1;
      wait_done("post_rst", 60);
      chk("final_aq", aq.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dac_arb.md
Name: dac_arb

Overview:
- Round-robin arbiter and sequencer that shares the single AD5331 DAC control register port among N on-chip requesters.
- Each requester hands over a 10-bit code, with or without a clear request. The block issues a one-cycle register write to the DAC controller and tracks the controller's busy flag until the conversion cycle ends. It then acknowledges the requester.
- The block also owns the power-down bit. Any change on pd_en is pushed to the DAC as a register write.
- Sits between the setpoint sources and the DAC controller register port. It replaces direct PCI writes to that port.

Parameters:
- N, 4, number of requesters (2..8).
- TIMEOUT, 255, maximum cycles in WAIT_LO before an error abort.
- HI_WIN, 3, maximum cycles in WAIT_HI for busy to assert after a write.

Ports:
- clk  in  1  system clock.
- rst_  in  1  asynchronous, active-low reset.
- req  in  N  level request per requester; held until ack.
- req_code  in  N*10  10-bit DAC code per requester, slice i = [10i+9:10i]; stable while req[i]=1.
- req_clr  in  N  1 = clear-DAC request instead of a code load.
- ack  out  N  one-cycle completion pulse to the granted requester.
- err  out  1  one-cycle pulse with ack on an aborted or timed-out operation.
- grant_id  out  3  index of the current or last granted requester.
- arb_busy  out  1  1 whenever state != IDLE.
- pd_en  in  1  1 = DAC powered; drives the PD_DAC field.
- dac_valid  out  1  register write strobe to the DAC controller.
- dac_sel  out  1  register select to the DAC controller.
- dac_rd_wr  out  1  constant 1 (write); readback never requested.
- dac_wdata  out  32  register word; fields packed with the g_define.vh macros: DAN_DAC_1 = code, CLR_DAC_1 = clr, PD_DAC = pd_en; all other bits 0.
- dac_busy  in  1  busy flag from the DAC controller.

Behaviour:
- Reset values: ack=0, err=0, dac_valid=0, dac_sel=0, dac_wdata=0, grant_id=0, arb_busy=0, dac_rd_wr=1, state=IDLE, rr pointer=N-1, pd_last=0, timeout counter=0.
- States: IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE.
- IDLE:
  - If pd_en != pd_last: load wdata with {last code, clr=0, PD=pd_en}, set pd_last=pd_en, mark the op internal (no ack), go to ISSUE. This has priority over all requests.
  - Else if pd_en=1 and any req is set: pick the first set req searching from pointer+1 mod N. Latch code/clr into wdata with PD=1, set grant_id, go to ISSUE.
  - pd_en=0 blocks all grants. Requests stay pending.
- ISSUE: exactly one cycle with dac_valid=1 and dac_sel=1. Next state is WAIT_HI.
- WAIT_HI: go to WAIT_LO on dac_busy=1. If busy is still 0 after HI_WIN cycles, flag an error and go to DONE.
- WAIT_LO:
  - Counter increments each cycle. On dac_busy=0, go to DONE without error.
  - If the counter reaches TIMEOUT, flag an error and go to DONE.
  - If pd_en falls here (not an internal op), flag an error and go to DONE.
- DONE: one cycle.
  - For a requester op: ack[grant_id]=1, err=flag, pointer=grant_id.
  - For an internal op: no ack and no err.
  - Then go to IDLE.
- Latency: req rises at cycle t in IDLE, ISSUE runs at t+1, WAIT_HI starts at t+2. The minimum total is the DAC controller cycle plus 3.
- Last code register: updated on each successful non-clear op and used for pd updates. Reset value is 0.
- A req still high in the cycle after its ack is treated as a new request. Requesters must drop req in the ack cycle to avoid a repeat.
- Simultaneous pd_en change and req: the pd update goes first, then the request is granted.
- A pd_en toggle mid-operation is recorded and handled in the next IDLE.
- Asynchronous reset mid-operation returns immediately to the reset values. No ack is issued.

Optional Feature:
- DAC_ARB_FIXED_PRIO_EN defined: requester 0, when set, wins over the round-robin choice in IDLE. Requesters 1..N-1 keep round-robin among themselves.
- Not defined: pure round-robin across all N.

Test Plan:
- Reset, then pd_en 0->1 -> exactly one ISSUE with PD=1, code 0, clr 0; no ack.
- pd_en=1, req[2]=1, code 10'h2A5, busy model asserting 1 cycle after write for 4 cycles -> dac_valid pulse carries 0x2A5; ack[2] pulses 1 cycle after busy falls; err=0.
- req=4'b1111 held, N=4, each dropped on its ack -> grant order 0,1,2,3. With DAC_ARB_FIXED_PRIO_EN and req[0] reasserted after grant 1 -> order 0,1,0,2,3.
- Busy model never asserts -> err and ack pulse together 3 cycles after WAIT_HI entry; arbiter returns to IDLE.
- Busy stuck high -> err and ack pulse after 255 WAIT_LO cycles.
- req[1] with req_clr[1]=1 -> CLR_DAC_1 set in wdata; last code unchanged. pd_en=0 with req[3] set -> no dac_valid until pd_en returns to 1.
